seg_serial_drv: RTL

//  Parametrised 7-segment display driver for the Sword board serial segment chain.

---
 rtl/seg_serial_drv.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seg_serial_drv.sv
// Serial 7-segment driver for the Sword board segment chain: encodes hex digits and shifts them out.
// Optional build macro SEG_DRV_BLINK_EN adds a per-digit blink input and a 4-bit frame counter.
module seg_serial_drv #(
  parameter int DIGITS       = 8,
  parameter int SCLK_DIV     = 1,
  parameter int REFRESH_LOG2 = 16,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dot,
  input  logic [DIGITS-1:0]     blank,
`ifdef SEG_DRV_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  output logic                  s_clk,
  output logic                  s_clrn,
  output logic                  sout,
  output logic                  EN,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAME_BITS = 8 * DIGITS;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [BIT_W-1:0]        LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0]        LAST_DIV = DIV_W'(SCLK_DIV - 1);
  localparam logic [REFRESH_LOG2-1:0] TIMER_TC = '1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  typedef struct packed {
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   dot;
    logic [DIGITS-1:0]   blank;
`ifdef SEG_DRV_BLINK_EN
    logic [DIGITS-1:0]   blink;
`endif
  } disp_t;

  state_t                  state, state_d;
  disp_t                   upd_bus, pend, shadow, load_src;
  logic                    pend_full;
  logic                    xfer;
  logic [FRAME_BITS-1:0]   shift_reg, enc_frame;
  logic [BIT_W-1:0]        bitcnt;
  logic [DIV_W-1:0]        divcnt;
  logic [REFRESH_LOG2-1:0] timer;
  logic [DIGITS-1:0]       blink_off;
  logic [7:0]              seg_byte;
`ifdef SEG_DRV_BLINK_EN
  logic [3:0]              frame_cnt;
`endif

  // Common-anode segment pattern {a,b,c,d,e,f,g,dp}; a 0 lights the segment.
  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: hex_code = 8'h03;  4'h1: hex_code = 8'h9F;
      4'h2: hex_code = 8'h25;  4'h3: hex_code = 8'h0D;
      4'h4: hex_code = 8'h99;  4'h5: hex_code = 8'h49;
      4'h6: hex_code = 8'h41;  4'h7: hex_code = 8'h1F;
      4'h8: hex_code = 8'h01;  4'h9: hex_code = 8'h09;
      4'hA: hex_code = 8'h11;  4'hB: hex_code = 8'hC1;
      4'hC: hex_code = 8'h63;  4'hD: hex_code = 8'h85;
      4'hE: hex_code = 8'h61;  default: hex_code = 8'h71;
    endcase
  endfunction

  assign xfer      = upd_valid && upd_ready;
  assign upd_ready = !pend_full;
  // LOAD takes a waiting update, otherwise the refresh re-sends the current shadow.
  assign load_src  = pend_full ? pend : shadow;

  always_comb begin
    upd_bus       = '0;
    upd_bus.num   = num;
    upd_bus.dot   = dot;
    upd_bus.blank = blank;
`ifdef SEG_DRV_BLINK_EN
    upd_bus.blink = blink;
`endif
  end

`ifdef SEG_DRV_BLINK_EN
  assign blink_off = load_src.blink & {DIGITS{frame_cnt[3]}};
`else
  assign blink_off = '0;
`endif

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    enc_frame = '0;
    seg_byte  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_byte = hex_code(load_src.num[4*i +: 4]);
      if (load_src.dot[i]) seg_byte[0] = 1'b0;
      if (load_src.blank[i] || blink_off[i]) seg_byte = 8'hFF;
      if (!COMMON_ANODE) seg_byte = ~seg_byte;
      enc_frame[8*i +: 8] = seg_byte;
    end
  end

  always_comb begin
    state_d    = state;
    s_clk      = 1'b0;
    sout       = 1'b0;
    EN         = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        EN   = s_clrn;
        if (pend_full || xfer || timer == TIMER_TC) state_d = LOAD;
      end
      LOAD: state_d = SHIFT_LO;
      SHIFT_LO: begin
        sout = shift_reg[FRAME_BITS-1];
        if (divcnt == LAST_DIV) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        s_clk = 1'b1;
        sout  = shift_reg[FRAME_BITS-1];
        if (divcnt == LAST_DIV) state_d = (bitcnt == LAST_BIT) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        EN         = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: pending and shadow display registers are reset too: the first frame
  // after reset must show all '0', not whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_clrn    <= 1'b0;
      pend      <= '0;
      pend_full <= 1'b0;
      shadow    <= '0;
      shift_reg <= '0;
      bitcnt    <= '0;
      divcnt    <= '0;
      timer     <= TIMER_TC;
`ifdef SEG_DRV_BLINK_EN
      frame_cnt <= '0;
`endif
    end else begin
      state  <= state_d;
      s_clrn <= 1'b1;

      if (state == LOAD && pend_full) begin
        shadow    <= pend;
        pend_full <= 1'b0;
      end else if (xfer) begin
        pend      <= upd_bus;
        pend_full <= 1'b1;
      end

      case (state)
        IDLE: timer <= timer + 1'b1;
        LOAD: begin
          shift_reg <= enc_frame;
          bitcnt    <= '0;
          divcnt    <= '0;
        end
        SHIFT_LO: divcnt <= (divcnt == LAST_DIV) ? '0 : divcnt + 1'b1;
        SHIFT_HI: begin
          if (divcnt == LAST_DIV) begin
            divcnt    <= '0;
            shift_reg <= shift_reg << 1;
            bitcnt    <= bitcnt + 1'b1;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        LATCH: begin
          timer <= '0;
`ifdef SEG_DRV_BLINK_EN
          frame_cnt <= frame_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
